dmem_arbiter: RTL and testbench

Two-requester arbiter and burst sequencer in front of the single-port word-addressed data memory. It accepts commands from port 0 (CPU load/store unit) and port 1 (DMA/debug loader), grants the memory to one port at a time, and sequences 1–4 word bursts with auto-incrementing addresses. It registers read data back to the owning port. It sits between the requesters and the data memory's `addr`/`writeData`/`writeEnable`/`read` pins.

---
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and 1-4 beat burst sequencer for the word-addressed data memory.
// Define DMARB_RR_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [1:0]        req0_len,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              beat0,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [1:0]        req1_len,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              beat1,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        len_q, len_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;

    logic              idle, burst, pick1;
    logic [DATA_W-1:0] rd_beat;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{req0_addr[1:0], req1_addr[1:0]};

    assign idle  = (state_q == S_IDLE);
    assign burst = (state_q == S_BURST);

`ifdef DMARB_RR_EN
    logic last_q, last_d;
    // last_q names the previous winner; a tie goes to the other port
    assign pick1 = req1_valid & (~req0_valid | ~last_q);
`else
    assign pick1 = req1_valid & ~req0_valid;
`endif

    assign req0_ready = rst_n & idle & req0_valid & ~pick1;
    assign req1_ready = rst_n & idle & pick1;

    assign beat0 = burst & ~owner_q;
    assign beat1 = burst & owner_q;

    assign mem_addr  = burst ? base_q + {{(ADDR_W-4){1'b0}}, cnt_q, 2'b00}
                             : '0;
    assign mem_we    = burst & we_q;
    assign mem_wdata = burst ? (owner_q ? req1_wdata : req0_wdata) : '0;
    assign rd_beat   = (burst & ~we_q) ? mem_rdata : '0;

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        base_d       = base_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
`ifdef DMARB_RR_EN
        last_d       = last_q;
`endif
        rsp0_valid_d = beat0;
        rsp1_valid_d = beat1;
        rsp0_rdata_d = beat0 ? rd_beat : '0;
        rsp1_rdata_d = beat1 ? rd_beat : '0;
        unique case (1'b1)
            idle: begin
                if (req0_valid | req1_valid) begin
                    state_d = S_BURST;
                    owner_d = pick1;
                    we_d    = pick1 ? req1_we : req0_we;
                    base_d  = pick1 ? {req1_addr[ADDR_W-1:2], 2'b00}
                                    : {req0_addr[ADDR_W-1:2], 2'b00};
                    len_d   = pick1 ? req1_len : req0_len;
                    cnt_d   = 2'd0;
`ifdef DMARB_RR_EN
                    last_d  = pick1;
`endif
                end
            end
            burst: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == len_q) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            base_q       <= '0;
            len_q        <= 2'd0;
            cnt_q        <= 2'd0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            base_q       <= base_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

`ifdef DMARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: burst-queue reference model checked every cycle plus directed literals.
module tb_dmem_arbiter;

`ifdef DMARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we, beat0, rsp0_valid;
    logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
    logic [1:0]  req0_len;
    logic        req1_valid, req1_ready, req1_we, beat1, rsp1_valid;
    logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
    logic [1:0]  req1_len;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_len(req0_len), .req0_wdata(req0_wdata),
        .beat0(beat0), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_len(req1_len), .req1_wdata(req1_wdata),
        .beat1(beat1), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    logic [31:0] dmem [0:255];
    logic [31:0] refm [0:255];

    assign mem_rdata = dmem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we === 1'b1) dmem[mem_addr[9:2]] <= mem_wdata;
    end

    typedef struct packed {
        logic        o;
        logic        w;
        logic [31:0] a;
    } beat_t;

    beat_t       bq[$];
    logic        pv, po, last_m;
    logic [31:0] pd;
    int          grants[$];
    int          gcyc[$];
    logic [31:0] rlog0[$], rlog1[$], alog[$];
    int          wecnt, cyc, checks, failures;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endtask

    // Reference: an accepted command expands into a queue of beats
    always @(negedge clk) begin : model
        logic        er0, er1, eb0, eb1, ev0, ev1, ewe, ok;
        logic [31:0] ea, ewd, eo0, eo1;
        logic [6:0]  actc, expc;
        logic        ww;
        logic [31:0] wa;
        logic [1:0]  wl;
        int          win, idx;
        er0 = 0; er1 = 0; eb0 = 0; eb1 = 0; ev0 = 0; ev1 = 0; ewe = 0;
        ea = 0; ewd = 0; eo0 = pd; eo1 = pd; win = -1;
        if (rst_n === 1'b1) begin
            ev0 = pv & ~po;
            ev1 = pv & po;
            if (bq.size() > 0) begin
                eb0 = ~bq[0].o;
                eb1 = bq[0].o;
                ea  = bq[0].a;
                ewe = bq[0].w;
                ewd = bq[0].o ? req1_wdata : req0_wdata;
            end else if (req0_valid | req1_valid) begin
                if (req0_valid & req1_valid)
                    win = (RR && last_m == 1'b0) ? 1 : 0;
                else
                    win = req1_valid ? 1 : 0;
                er0 = (win == 0);
                er1 = (win == 1);
            end
        end
        actc = {req0_ready, req1_ready, beat0, beat1, rsp0_valid, rsp1_valid, mem_we};
        expc = {er0, er1, eb0, eb1, ev0, ev1, ewe};
        ok = (actc === expc) && (mem_addr === ea) && (mem_wdata === ewd)
             && (!ev0 || rsp0_rdata === eo0) && (!ev1 || rsp1_rdata === eo1);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL cycle%0d got ctl=%b addr=%h wd=%h d0=%h d1=%h want ctl=%b addr=%h wd=%h d=%h",
                     cyc, actc, mem_addr, mem_wdata, rsp0_rdata, rsp1_rdata,
                     expc, ea, ewd, pd);
        end
        if (rsp0_valid === 1'b1) rlog0.push_back(rsp0_rdata);
        if (rsp1_valid === 1'b1) rlog1.push_back(rsp1_rdata);
        if ((beat0 | beat1) === 1'b1) alog.push_back(mem_addr);
        if (mem_we === 1'b1) wecnt++;
        if (rst_n !== 1'b1) begin
            bq.delete();
            pv = 0;
            last_m = 1;
        end else begin
            pv = 0;
            if (bq.size() > 0) begin
                idx = int'(bq[0].a[9:2]);
                pv = 1;
                po = bq[0].o;
                pd = bq[0].w ? 32'h0 : refm[idx];
                if (bq[0].w) refm[idx] = ewd;
                void'(bq.pop_front());
            end else if (win >= 0) begin
                ww = win[0] ? req1_we : req0_we;
                wa = win[0] ? req1_addr : req0_addr;
                wl = win[0] ? req1_len : req0_len;
                wa[1:0] = 2'b00;
                for (int k = 0; k <= int'(wl); k++)
                    bq.push_back('{o: win[0], w: ww, a: wa + 32'(4 * k)});
                last_m = win[0];
                grants.push_back(win);
                gcyc.push_back(cyc);
            end
        end
        cyc++;
    end

    task automatic issue(input int p, input logic w, input logic [31:0] a,
                         input logic [1:0] l, input logic [31:0] wd);
        bit got;
        if (p == 0) begin
            req0_we = w; req0_addr = a; req0_len = l; req0_wdata = wd; req0_valid = 1;
        end else begin
            req1_we = w; req1_addr = a; req1_len = l; req1_wdata = wd; req1_valid = 1;
        end
        got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            got = (p == 0) ? req0_ready : req1_ready;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout port=%0d got=0 want=1", p);
            if (p == 0) req0_valid = 0; else req1_valid = 0;
            return;
        end
        @(posedge clk); #2;
        if (p == 0) req0_valid = 0; else req1_valid = 0;
        for (int k = 1; k <= int'(l); k++) begin
            @(posedge clk); #2;
            if (p == 0) req0_wdata = wd + 32'(k); else req1_wdata = wd + 32'(k);
        end
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        checks = 0; failures = 0; wecnt = 0; cyc = 0;
        pv = 0; po = 0; pd = 0; last_m = 1;
        for (int i = 0; i < 256; i++) begin
            dmem[i] = 32'h0;
            refm[i] = 32'h0;
        end
        dmem[0] = 12; dmem[1] = 10; dmem[2] = 15; dmem[3] = 99; dmem[255] = 32'h55;
        refm[0] = 12; refm[1] = 10; refm[2] = 15; refm[3] = 99; refm[255] = 32'h55;
        rst_n = 0;
        req0_valid = 1; req0_we = 0; req0_addr = 0; req0_len = 0; req0_wdata = 0;
        req1_valid = 1; req1_we = 0; req1_addr = 0; req1_len = 0; req1_wdata = 0;
        @(posedge clk); #2;
        chk("rst_ready0", {31'h0, req0_ready}, 0);
        chk("rst_ready1", {31'h0, req1_ready}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); #2 rst_n = 1;

        // single read burst
        alog.delete(); rlog0.delete();
        issue(0, 0, 32'h4, 2'd1, 0);
        repeat (2) @(posedge clk); #2;
        chk("rd_addr_n", alog.size(), 2);
        chk("rd_addr0", alog.size() > 0 ? alog[0] : 32'hdead, 32'h4);
        chk("rd_addr1", alog.size() > 1 ? alog[1] : 32'hdead, 32'h8);
        chk("rd_rsp_n", rlog0.size(), 2);
        chk("rd_data0", rlog0.size() > 0 ? rlog0[0] : 32'hdead, 10);
        chk("rd_data1", rlog0.size() > 1 ? rlog0[1] : 32'hdead, 15);

        // write then read back on port 1
        wecnt = 0; rlog1.delete();
        issue(1, 1, 32'h10, 2'd0, 7);
        issue(1, 0, 32'h10, 2'd0, 0);
        repeat (2) @(posedge clk); #2;
        chk("wr_we_cycles", wecnt, 1);
        chk("wr_rsp_n", rlog1.size(), 2);
        chk("wr_rsp_data", rlog1.size() > 0 ? rlog1[0] : 32'hdead, 0);
        chk("wr_readback", rlog1.size() > 1 ? rlog1[1] : 32'hdead, 7);

        // tie right after reset
        do_reset();
        grants.delete(); gcyc.delete();
        fork
            issue(0, 0, 32'h0, 2'd1, 0);
            issue(1, 0, 32'h8, 2'd0, 0);
        join
        repeat (2) @(posedge clk); #2;
        chk("tie_n", grants.size(), 2);
        chk("tie_first", grants.size() > 0 ? grants[0] : 9, 0);
        chk("tie_second", grants.size() > 1 ? grants[1] : 9, 1);
        chk("tie_gap", gcyc.size() > 1 ? gcyc[1] - gcyc[0] : 99, 3);

        // continuous contention
        grants.delete();
        fork
            repeat (3) issue(0, 0, 32'h0, 2'd0, 0);
            repeat (3) issue(1, 0, 32'h4, 2'd0, 0);
        join
        repeat (2) @(posedge clk); #2;
        chk("cont_n", grants.size(), 6);
        chk("cont_g0", grants.size() > 0 ? grants[0] : 9, 0);
        chk("cont_g1", grants.size() > 1 ? grants[1] : 9, RR ? 1 : 0);
        chk("cont_g2", grants.size() > 2 ? grants[2] : 9, 0);
        chk("cont_g3", grants.size() > 3 ? grants[3] : 9, 1);

        // address wrap
        alog.delete(); rlog0.delete();
        issue(0, 0, 32'hFFFF_FFFE, 2'd1, 0);
        repeat (2) @(posedge clk); #2;
        chk("wrap_addr0", alog.size() > 0 ? alog[0] : 32'hdead, 32'hFFFF_FFFC);
        chk("wrap_addr1", alog.size() > 1 ? alog[1] : 32'hdead, 32'h0);
        chk("wrap_data0", rlog0.size() > 0 ? rlog0[0] : 32'hdead, 32'h55);
        chk("wrap_data1", rlog0.size() > 1 ? rlog0[1] : 32'hdead, 12);

        // reset in the middle of a 4-beat write
        rlog1.delete();
        req1_we = 1; req1_addr = 32'h20; req1_len = 2'd3; req1_wdata = 32'hA1;
        req1_valid = 1;
        got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            got = req1_ready;
        end
        chk("abort_accept", {31'h0, got}, 1);
        @(posedge clk); #2 req1_valid = 0;
        @(posedge clk); #2 req1_wdata = 32'hA2;
        @(posedge clk); #2 rst_n = 0;
        #1;
        chk("abort_we", {31'h0, mem_we}, 0);
        chk("abort_beat1", {31'h0, beat1}, 0);
        chk("abort_addr", mem_addr, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        req1_we = 0; req1_addr = 0; req1_len = 0; req1_wdata = 0;
        repeat (3) @(posedge clk); #2;
        chk("abort_m8", dmem[8], 32'hA1);
        chk("abort_m9", dmem[9], 32'hA2);
        chk("abort_m10", dmem[10], 0);
        chk("abort_m11", dmem[11], 0);
        chk("abort_rsp_n", rlog1.size(), 1);

        // arbiter usable again after the abort
        rlog0.delete();
        issue(0, 0, 32'h4, 2'd0, 0);
        repeat (2) @(posedge clk); #2;
        chk("post_rd", rlog0.size() > 0 ? rlog0[0] : 32'hdead, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
